// File: rtl/writeback_stage_if.sv
// Writeback stage bus.
// Groups the memory-access stage inputs (instruction valid, flush/hold
// controls, source select, candidate data values, destination and write
// enable) with the register-file write port, the forwarding entry and the
// retired-instruction counter.
//   master  : memory-access side; drives the instruction inputs, observes results
//   slave   : writeback stage; consumes the instruction inputs, drives results
interface writeback_stage_if #(
    parameter int CNT_W = 64
);
    logic             in_valid;
    logic             flush;
    logic             hold;
    logic [1:0]       wb_sel;
    logic [31:0]      alu_result;
    logic [31:0]      mem_rdata;
    logic [31:0]      immediate;
    logic [31:0]      pc_next;
    logic [4:0]       rd;
    logic             reg_we;

    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [31:0]      fwd_data;
    logic [CNT_W-1:0] instret;

    modport master (
        output in_valid, flush, hold, wb_sel, alu_result, mem_rdata,
               immediate, pc_next, rd, reg_we,
        input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, instret
    );

    modport slave (
        input  in_valid, flush, hold, wb_sel, alu_result, mem_rdata,
               immediate, pc_next, rd, reg_we,
        output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, instret
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage of the pipeline.
// Selects the writeback value (ALU / MEM / PC_NEXT / IMM), registers it with
// the destination index, and presents it to the register file exactly once
// per instruction, even while the stage is held. A forwarding entry stays
// visible for as long as the instruction sits in the stage. instret counts
// retired instructions and wraps silently.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   wb   : writeback_stage_if.slave (instruction inputs, rf write port,
//          forwarding entry, instret)
module writeback_stage #(
    parameter int CNT_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    writeback_stage_if.slave   wb
);
    // EMPTY: bubble; PENDING: valid, not yet written; DONE: valid, already written
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic             reg_we_q,  reg_we_d;
    logic [4:0]       rd_q,      rd_d;
    logic [31:0]      data_q,    data_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [31:0]      sel_data;
    logic             valid;
    logic             fwd_ok;
    logic             write_now;

    // Source mux sits ahead of the register so only 32 bits are stored.
    always_comb begin
        sel_data = wb.alu_result;
        case (wb.wb_sel)
            2'b00:   sel_data = wb.alu_result;
            2'b01:   sel_data = wb.mem_rdata;
            2'b10:   sel_data = wb.pc_next;
            2'b11:   sel_data = wb.immediate;
            default: sel_data = wb.alu_result;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        reg_we_d = reg_we_q;
        rd_d     = rd_q;
        data_d   = data_q;
        // An entry is retired during the one cycle it is PENDING.
        instret_d = instret_q + ((state_q == PENDING) ? CNT_W'(1) : '0);

        if (wb.flush) begin
            // Flush beats hold: always drop to a bubble.
            state_d  = EMPTY;
            reg_we_d = 1'b0;
            rd_d     = 5'd0;
            data_d   = 32'd0;
        end else if (wb.hold) begin
            // Contents frozen; a presented entry becomes DONE so it is not
            // written or counted a second time.
            if (state_q == PENDING) begin
                state_d = DONE;
            end
        end else if (wb.in_valid) begin
            state_d  = PENDING;
            reg_we_d = wb.reg_we;
            rd_d     = wb.rd;
            data_d   = sel_data;
        end else begin
            state_d  = EMPTY;
            reg_we_d = 1'b0;
            rd_d     = 5'd0;
            data_d   = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            reg_we_q  <= 1'b0;
            rd_q      <= 5'd0;
            data_q    <= 32'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            reg_we_q  <= reg_we_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            instret_q <= instret_d;
        end
    end

    assign valid     = (state_q != EMPTY);
    assign fwd_ok    = valid & reg_we_q & (rd_q != 5'd0);
    assign write_now = fwd_ok & (state_q == PENDING);

    assign wb.rf_we     = write_now;
    assign wb.rf_waddr  = write_now ? rd_q   : 5'd0;
    assign wb.rf_wdata  = write_now ? data_q : 32'd0;
    assign wb.fwd_valid = fwd_ok;
    assign wb.fwd_rd    = fwd_ok ? rd_q   : 5'd0;
    assign wb.fwd_data  = fwd_ok ? data_q : 32'd0;
    assign wb.instret   = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    writeback_stage_if #(.CNT_W(CW)) bus ();

    writeback_stage #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rf_we;
        logic [4:0]    waddr;
        logic [31:0]   wdata;
        logic          fv;
        logic [4:0]    frd;
        logic [31:0]   fdata;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;

    // Reference model of the stage contents
    logic          m_valid, m_written, m_we;
    logic [4:0]    m_rd;
    logic [31:0]   m_data;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_written = 0; m_we = 0; m_rd = 0; m_data = 0; m_cnt = 0;
    endtask

    task automatic step(input logic v, input logic f, input logic h, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd, input logic we,
                        input string tag);
        exp_t e, o;
        logic fv;
        bus.in_valid = v; bus.flush = f; bus.hold = h; bus.wb_sel = sel;
        bus.alu_result = alu; bus.mem_rdata = mem; bus.immediate = imm;
        bus.pc_next = pc; bus.rd = rd; bus.reg_we = we;

        if (m_valid && !m_written) m_cnt = m_cnt + 1'b1;
        if (f) begin
            m_valid = 0; m_written = 0; m_we = 0; m_rd = 0; m_data = 0;
        end else if (h) begin
            if (m_valid) m_written = 1;
        end else if (v) begin
            m_valid = 1; m_written = 0; m_we = we; m_rd = rd;
            m_data = (sel == 2'b00) ? alu : (sel == 2'b01) ? mem : (sel == 2'b10) ? pc : imm;
        end else begin
            m_valid = 0; m_written = 0; m_we = 0; m_rd = 0; m_data = 0;
        end
        fv = m_valid && m_we && (m_rd != 0);
        e.fv    = fv;
        e.frd   = fv ? m_rd : 5'd0;
        e.fdata = fv ? m_data : 32'd0;
        e.rf_we = fv && !m_written;
        e.waddr = e.rf_we ? m_rd : 5'd0;
        e.wdata = e.rf_we ? m_data : 32'd0;
        e.cnt   = m_cnt;
        sb.push_back(e);

        @(posedge clk);
        #1;
        n_step++;
        e = sb.pop_front();
        o = '{bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fwd_valid, bus.fwd_rd, bus.fwd_data, bus.instret};
        chk({tag, ".rf_we"},     64'(o.rf_we), 64'(e.rf_we));
        chk({tag, ".rf_waddr"},  64'(o.waddr), 64'(e.waddr));
        chk({tag, ".rf_wdata"},  64'(o.wdata), 64'(e.wdata));
        chk({tag, ".fwd_valid"}, 64'(o.fv),    64'(e.fv));
        chk({tag, ".fwd_rd"},    64'(o.frd),   64'(e.frd));
        chk({tag, ".fwd_data"},  64'(o.fdata), 64'(e.fdata));
        chk({tag, ".instret"},   64'(o.cnt),   64'(e.cnt));
        $display("step %0d %s: rf_we=%b waddr=%0d wdata=%h fwd=%b/%0d/%h instret=%0d",
                 n_step, tag, o.rf_we, o.waddr, o.wdata, o.fv, o.frd, o.fdata, o.cnt);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rf_we"},     64'(bus.rf_we), 0);
        chk({tag, ".rf_waddr"},  64'(bus.rf_waddr), 0);
        chk({tag, ".rf_wdata"},  64'(bus.rf_wdata), 0);
        chk({tag, ".fwd_valid"}, 64'(bus.fwd_valid), 0);
        chk({tag, ".fwd_rd"},    64'(bus.fwd_rd), 0);
        chk({tag, ".fwd_data"},  64'(bus.fwd_data), 0);
        chk({tag, ".instret"},   64'(bus.instret), 0);
    endtask

    initial begin
        int we_cnt, fv_cnt;
        logic [CW-1:0] c0;
        bus.in_valid = 0; bus.flush = 0; bus.hold = 0; bus.wb_sel = 0;
        bus.alu_result = 0; bus.mem_rdata = 0; bus.immediate = 0;
        bus.pc_next = 0; bus.rd = 0; bus.reg_we = 0;
        model_reset();

        // Reset state
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 0;

        // MEM load, counted on the following edge
        step(1, 0, 0, 2'b01, 32'h1111, 32'hDEADBEEF, 0, 0, 5'd5, 1, "load_mem");
        chk("load_mem.direct_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        chk("load_mem.direct_instret0", 64'(bus.instret), 0);
        step(1, 0, 0, 2'b10, 0, 0, 0, 32'h104, 5'd1, 1, "jal_pc");
        chk("load_mem.direct_instret1", 64'(bus.instret), 1);
        chk("jal_pc.direct_wdata", 64'(bus.rf_wdata), 64'h104);
        step(1, 0, 0, 2'b11, 0, 0, 32'h12345000, 0, 5'd2, 1, "imm");
        chk("imm.direct_wdata", 64'(bus.rf_wdata), 64'h12345000);
        step(1, 0, 0, 2'b00, 32'hA5A5_0001, 0, 0, 0, 5'd31, 1, "alu");

        // x0 destination: no write, still retired
        step(1, 0, 0, 2'b00, 32'd7, 0, 0, 0, 5'd0, 1, "x0");
        chk("x0.direct_rf_we", 64'(bus.rf_we), 0);
        step(1, 0, 0, 2'b00, 32'd9, 0, 0, 0, 5'd8, 0, "no_we");
        idle("bubble");
        chk("x0.direct_instret", 64'(bus.instret), 6);

        // Hold for 3 cycles: one write, four forwarding cycles, one count
        c0 = bus.instret;
        step(1, 0, 0, 2'b00, 32'h33, 0, 0, 0, 5'd3, 1, "hold_load");
        we_cnt = int'(bus.rf_we); fv_cnt = int'(bus.fwd_valid);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 2'b01, 32'hBAD, 32'hBAD, 0, 0, 5'd9, 1, "hold");
            we_cnt += int'(bus.rf_we); fv_cnt += int'(bus.fwd_valid);
        end
        chk("hold.direct_we_cycles", 64'(we_cnt), 1);
        chk("hold.direct_fwd_cycles", 64'(fv_cnt), 4);
        chk("hold.direct_instret", 64'(bus.instret), 64'(c0 + 1'b1));
        idle("hold_done");

        // Flush under hold, then flush with a valid instruction
        step(1, 0, 0, 2'b00, 32'h44, 0, 0, 0, 5'd4, 1, "fl_load");
        step(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, "fl_hold");
        step(1, 1, 1, 2'b00, 32'h55, 0, 0, 0, 5'd5, 1, "flush_hold");
        step(1, 1, 0, 2'b00, 32'h66, 0, 0, 0, 5'd6, 1, "flush_valid");
        idle("fl_after");

        // Asynchronous reset mid-operation
        step(1, 0, 0, 2'b00, 32'h77, 0, 0, 0, 5'd7, 1, "pre_rst");
        #2 rst = 1;
        #1 chk_zero("async_rst");
        model_reset();
        #2 rst = 0;
        idle("post_rst");

        // Wrap after 16 retirements
        for (int i = 0; i < 16; i++)
            step(1, 0, 0, 2'(i), 32'(i), 32'(i + 100), 32'(i + 200), 32'(i + 300), 5'(i), 1, "wrap");
        chk("wrap.direct_15", 64'(bus.instret), 15);
        idle("wrap_end");
        chk("wrap.direct_0", 64'(bus.instret), 0);

        // Random mix
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                 1'($urandom), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: CNT_W, 64, width of the retired-instruction counter (legal range 1..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  memory-access stage presents a valid instruction this cycle.
REQ-005 flush  input  1  discard the incoming instruction.
REQ-006 hold  input  1  freeze the stage register.
REQ-007 wb_sel  input  2  writeback source: 00 ALU, 01 MEM, 10 PC_NEXT, 11 IMM.
REQ-008 alu_result  input  32  ALU result from memory-access stage.
REQ-009 mem_rdata  input  32  load data, already aligned and extended.
REQ-010 immediate  input  32  immediate value.
REQ-011 pc_next  input  32  return address for jumps.
REQ-012 rd  input  5  destination register index.
REQ-013 reg_we  input  1  instruction writes the register file.
REQ-014 rf_we  output  1  register-file write enable.
REQ-015 rf_waddr  output  5  register-file write index.
REQ-016 rf_wdata  output  32  register-file write data.
REQ-017 fwd_valid  output  1  forwarding entry is valid.
REQ-018 fwd_rd  output  5  forwarding destination index.
REQ-019 fwd_data  output  32  forwarding data.
REQ-020 instret  output  CNT_W  count of retired instructions.

Function
REQ-021 The stage register (valid, reg_we, rd, selected data) SHALL capture inputs on the clock edge when hold=0; this gives 1-cycle latency from input to rf_we.
REQ-022 The source mux SHALL be applied before the register; only the 32-bit selected value is stored.
REQ-023 Loading SHALL set valid=in_valid & ~flush; when valid=0, the register SHALL hold a bubble (reg_we=0, rd=0, data=0).
REQ-024 When hold=1 and flush=0, the register SHALL keep its contents.
REQ-025 When hold=1 and flush=1, the stage SHALL load a bubble, because flush takes priority over hold.
REQ-026 An internal flag "written" SHALL be cleared on every load and set after the first cycle a valid entry is presented.
REQ-027 rf_we SHALL equal valid & reg_we & (rd!=0) & ~written, so that each instruction writes the register file at most once, even across hold cycles.
REQ-028 rf_waddr SHALL equal the registered rd, and rf_wdata SHALL equal the registered data.
REQ-029 While rf_we=0, rf_waddr and rf_wdata SHALL be forced to 0.
REQ-030 fwd_valid SHALL equal valid & reg_we & (rd!=0), and SHALL remain asserted through hold, independent of "written".
REQ-031 fwd_rd and fwd_data SHALL mirror the registered rd and data.
REQ-032 fwd_rd and fwd_data SHALL be 0 while fwd_valid=0.
REQ-033 instret SHALL increment by 1 on each cycle where valid=1 and written=0, i.e. once per retired instruction, including instructions with reg_we=0 or rd=0.
REQ-034 instret SHALL wrap modulo 2^CNT_W without any flag.
REQ-035 The FSM per entry SHALL have states EMPTY (valid=0), PENDING (valid=1, written=0) and DONE (valid=1, written=1).
REQ-036 EMPTY/PENDING/DONE SHALL go to PENDING on a valid load, and to EMPTY on a bubble load.
REQ-037 Under hold, PENDING SHALL go to DONE, and DONE SHALL stay DONE.
REQ-038 Under hold with flush, any state SHALL go to EMPTY.

Reset
REQ-039 Asserting rst SHALL immediately set valid=0, written=0, rd=0, data=0, instret=0, and all outputs to 0, regardless of clk.
REQ-040 On the first edge after rst deasserts, the stage SHALL load normally.
REQ-041 An instruction captured before rst is asserted mid-operation SHALL NOT be written or counted.

Verification
REQ-042 Load: in_valid=1, wb_sel=01, mem_rdata=0xDEADBEEF, rd=5, reg_we=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, instret 0->1.
REQ-043 JAL: wb_sel=10, pc_next=0x00000104, rd=1 -> rf_wdata=0x104; with wb_sel=11, immediate=0x12345000 -> rf_wdata=0x12345000.
REQ-044 x0: rd=0, reg_we=1, alu_result=7 -> rf_we=0, fwd_valid=0, instret still increments.
REQ-045 Hold: valid entry rd=3, then hold=1 for 3 cycles -> rf_we high exactly 1 cycle, fwd_valid high all 4 cycles, instret +1 total.
REQ-046 Flush plus hold: hold=1, flush=1 while an entry is held -> next cycle valid=0, all outputs 0; flush=1 with in_valid=1 -> nothing written or counted.
REQ-047 Reset and wrap: CNT_W=4, retire 16 instructions -> instret wraps to 0; assert rst asynchronously between edges -> outputs are 0 before the next clk edge.
